writeback_queue: RTL and testbench

Buffers completed results (destination register plus 64-bit value) from the execute/memory side and drains them, one per granted cycle, into the register file's single write port (`reg_write`/`rd_addr`/`rd_data`). It sits directly upstream of the register file and absorbs cycles where the write port is given to another producer. It also provides forwarding lookups, so operand reads see values that are still queued and not yet committed.

---
 rtl/rv_pkg.sv | 14 +
 rtl/wbq_fwd_lookup.sv | 32 +++
 rtl/writeback_queue.sv | 105 ++++++++++
 tb/tb_writeback_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file types used by the writeback path: address width, x0
// and the queued result entry.
package rv_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_lookup.sv
// Youngest-match search over the writeback queue for one operand read port.
// Entries are visited oldest to youngest from head, so the last match wins.
module wbq_fwd_lookup
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wb_entry_t             entries [DEPTH],
    input  logic [DEPTH-1:0]      valid,
    input  logic [PTR_W-1:0]      head,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (addr != REG_X0 && valid[idx] && entries[idx].rd_addr == addr) begin
                hit  = 1'b1;
                data = entries[idx].rd_data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Circular buffer of completed results draining into the register file's
// single write port, with per-operand forwarding of still-queued values.
module writeback_queue
    import rv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_ADDR_W-1:0]      in_rd_addr,
    input  logic [XLEN-1:0]            in_rd_data,
    input  logic                       rf_grant,
    output logic                       rf_reg_write,
    output logic [REG_ADDR_W-1:0]      rf_rd_addr,
    output logic [XLEN-1:0]            rf_rd_data,
    input  logic [REG_ADDR_W-1:0]      fwd_rs1_addr,
    input  logic [REG_ADDR_W-1:0]      fwd_rs2_addr,
    output logic                       fwd_rs1_hit,
    output logic                       fwd_rs2_hit,
    output logic [XLEN-1:0]            fwd_rs1_data,
    output logic [XLEN-1:0]            fwd_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int EW    = rv_pkg::XLEN;

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid_mask;
    logic             push, pop;
    logic [EW-1:0]    rs1_data_w, rs2_data_w;

    // Handshake: a beat transfers on any cycle with in_valid && in_ready; the
    // producer must not wait for in_ready before raising in_valid, and in_ready
    // may rise combinationally with rf_grant when the queue is full.
    assign empty        = (count_q == '0);
    assign rf_reg_write = !empty && rf_grant;
    assign in_ready     = (count_q < CNT_W'(DEPTH)) || rf_reg_write;
    assign push         = in_valid && in_ready && (in_rd_addr != REG_X0);
    assign pop          = rf_reg_write;
    assign count        = count_q;

    assign rf_rd_addr = empty ? REG_X0 : mem[head_q].rd_addr;
    assign rf_rd_data = empty ? '0 : XLEN'(mem[head_q].rd_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= '{rd_addr: in_rd_addr, rd_data: EW'(in_rd_data)};
        end
    end

    // Slot i is occupied when its distance from head is below the count.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
        end
    end

    wbq_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs1 (
        .entries (mem),
        .valid   (valid_mask),
        .head    (head_q),
        .addr    (fwd_rs1_addr),
        .hit     (fwd_rs1_hit),
        .data    (rs1_data_w)
    );

    wbq_fwd_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd_rs2 (
        .entries (mem),
        .valid   (valid_mask),
        .head    (head_q),
        .addr    (fwd_rs2_addr),
        .hit     (fwd_rs2_hit),
        .data    (rs2_data_w)
    );

    assign fwd_rs1_data = XLEN'(rs1_data_w);
    assign fwd_rs2_data = XLEN'(rs2_data_w);

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: drain order, full-queue streaming,
// forwarding priority, x0 filtering and asynchronous reset.
module tb_writeback_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic [63:0] in_rd_data;
    logic        rf_grant;
    logic        rf_reg_write;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;
    logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [63:0] fwd_rs1_data, fwd_rs2_data;
    logic [2:0]  count;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  exp_addr_q[$];
    logic [63:0] exp_data_q[$];

    writeback_queue #(.XLEN(64), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd_addr   (in_rd_addr),
        .in_rd_data   (in_rd_data),
        .rf_grant     (rf_grant),
        .rf_reg_write (rf_reg_write),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .fwd_rs1_addr (fwd_rs1_addr),
        .fwd_rs2_addr (fwd_rs2_addr),
        .fwd_rs1_hit  (fwd_rs1_hit),
        .fwd_rs2_hit  (fwd_rs2_hit),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data),
        .count        (count),
        .empty        (empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [4:0] a, input logic [63:0] d);
        in_valid   = 1'b1;
        in_rd_addr = a;
        in_rd_data = d;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_rd_addr = '0; in_rd_data = '0;
        rf_grant = 1'b1; fwd_rs1_addr = 5'd5; fwd_rs2_addr = 5'd6;
        tick(); tick();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 || rf_reg_write !== 1'b0) begin
            $display("FAIL reset_ctrl: count=%0d empty=%b in_ready=%b wr=%b want 0/1/1/0", count, empty, in_ready, rf_reg_write);
            failures++;
        end
        checks++;
        if (rf_rd_addr !== 5'd0 || rf_rd_data !== 64'd0 || fwd_rs1_hit !== 1'b0 || fwd_rs2_hit !== 1'b0 ||
            fwd_rs1_data !== 64'd0 || fwd_rs2_data !== 64'd0) begin
            $display("FAIL reset_data: addr=%0d data=%h h1=%b h2=%b d1=%h d2=%h want all 0",
                     rf_rd_addr, rf_rd_data, fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data);
            failures++;
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rf_grant = 1'b1;
        in_valid = 1'b1; in_rd_addr = 5'd5; in_rd_data = 64'hDEAD_BEEF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL single_ready: got %b want 1", in_ready); failures++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (rf_reg_write !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 64'hDEAD_BEEF) begin
            $display("FAIL single_write: wr=%b addr=%0d data=%h want 1/5/deadbeef", rf_reg_write, rf_rd_addr, rf_rd_data);
            failures++;
        end
        tick();
        checks++;
        if (empty !== 1'b1 || rf_reg_write !== 1'b0) begin
            $display("FAIL single_empty: empty=%b wr=%b want 1/0", empty, rf_reg_write); failures++;
        end
    endtask

    task automatic test_fill_drain();
        rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push_beat(5'(i), 64'(i));
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || rf_reg_write !== 1'b0) begin
            $display("FAIL full_state: count=%0d in_ready=%b wr=%b want 4/0/0", count, in_ready, rf_reg_write);
            failures++;
        end
        rf_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (rf_reg_write !== 1'b1 || rf_rd_addr !== 5'(i) || rf_rd_data !== 64'(i) || in_ready !== 1'b1) begin
                $display("FAIL drain_%0d: wr=%b addr=%0d data=%h rdy=%b want 1/%0d/%0d/1",
                         i, rf_reg_write, rf_rd_addr, rf_rd_data, in_ready, i, i);
                failures++;
            end
            tick();
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0) begin
            $display("FAIL drain_empty: empty=%b count=%0d want 1/0", empty, count); failures++;
        end
    endtask

    task automatic test_back_to_back();
        rf_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_beat(5'(8 + i), 64'h100 + 64'(i));
            exp_addr_q.push_back(5'(8 + i));
            exp_data_q.push_back(64'h100 + 64'(i));
        end
        rf_grant = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_rd_addr = 5'(12 + c); in_rd_data = 64'h200 + 64'(c);
            #1;
            checks++;
            if (in_ready !== 1'b1 || rf_reg_write !== 1'b1 || count !== 3'd4 ||
                rf_rd_addr !== exp_addr_q[0] || rf_rd_data !== exp_data_q[0]) begin
                $display("FAIL stream_%0d: rdy=%b wr=%b count=%0d addr=%0d data=%h want 1/1/4/%0d/%h",
                         c, in_ready, rf_reg_write, count, rf_rd_addr, rf_rd_data, exp_addr_q[0], exp_data_q[0]);
                failures++;
            end
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            exp_addr_q.push_back(5'(12 + c));
            exp_data_q.push_back(64'h200 + 64'(c));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rf_reg_write !== 1'b1 || count !== 3'(4 - k) ||
                rf_rd_addr !== exp_addr_q[0] || rf_rd_data !== exp_data_q[0]) begin
                $display("FAIL stream_drain_%0d: wr=%b count=%0d addr=%0d data=%h want 1/%0d/%0d/%h",
                         k, rf_reg_write, count, rf_rd_addr, rf_rd_data, 4 - k, exp_addr_q[0], exp_data_q[0]);
                failures++;
            end
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
            tick();
        end
        checks++;
        if (empty !== 1'b1) begin
            $display("FAIL stream_empty: empty=%b want 1", empty); failures++;
        end
    endtask

    task automatic test_forward();
        rf_grant = 1'b0;
        fwd_rs1_addr = 5'd7; fwd_rs2_addr = 5'd9;
        push_beat(5'd7, 64'h11);
        in_valid = 1'b1; in_rd_addr = 5'd7; in_rd_data = 64'h22;
        #1;
        checks++;
        if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 64'h11) begin
            $display("FAIL fwd_first: hit=%b data=%h want 1/11", fwd_rs1_hit, fwd_rs1_data); failures++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 64'h22 || fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 64'd0) begin
            $display("FAIL fwd_youngest: hit1=%b d1=%h hit2=%b d2=%h want 1/22/0/0",
                     fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data);
            failures++;
        end
        rf_grant = 1'b1;
        tick();
        checks++;
        if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 64'h22 || count !== 3'd1) begin
            $display("FAIL fwd_popping: hit=%b data=%h count=%0d want 1/22/1", fwd_rs1_hit, fwd_rs1_data, count);
            failures++;
        end
        tick();
        rf_grant = 1'b0;
        #1;
        checks++;
        if (fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 64'd0) begin
            $display("FAIL fwd_gone: hit=%b data=%h want 0/0", fwd_rs1_hit, fwd_rs1_data); failures++;
        end
    endtask

    task automatic test_x0();
        rf_grant = 1'b0;
        fwd_rs2_addr = 5'd0;
        in_valid = 1'b1; in_rd_addr = 5'd0; in_rd_data = 64'hFF;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL x0_ready: got %b want 1", in_ready); failures++;
        end
        tick();
        in_valid = 1'b0;
        rf_grant = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || rf_reg_write !== 1'b0 || fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 64'd0) begin
            $display("FAIL x0_dropped: count=%0d wr=%b hit=%b data=%h want 0/0/0/0",
                     count, rf_reg_write, fwd_rs2_hit, fwd_rs2_data);
            failures++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        rf_grant = 1'b0;
        fwd_rs1_addr = 5'd3;
        push_beat(5'd3, 64'h33);
        push_beat(5'd4, 64'h44);
        push_beat(5'd5, 64'h55);
        #1;
        checks++;
        if (count !== 3'd3 || fwd_rs1_hit !== 1'b1) begin
            $display("FAIL pre_reset: count=%0d hit=%b want 3/1", count, fwd_rs1_hit); failures++;
        end
        rf_grant = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || in_ready !== 1'b1 || rf_reg_write !== 1'b0 ||
            rf_rd_addr !== 5'd0 || rf_rd_data !== 64'd0 || fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 64'd0) begin
            $display("FAIL async_reset: count=%0d empty=%b rdy=%b wr=%b addr=%0d data=%h hit=%b fd=%h want reset values",
                     count, empty, in_ready, rf_reg_write, rf_rd_addr, rf_rd_data, fwd_rs1_hit, fwd_rs1_data);
            failures++;
        end
        tick();
        checks++;
        if (rf_reg_write !== 1'b0) begin
            $display("FAIL write_in_reset: wr=%b want 0", rf_reg_write); failures++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rf_reg_write !== 1'b0 || empty !== 1'b1) begin
                $display("FAIL stale_%0d: wr=%b empty=%b want 0/1", c, rf_reg_write, empty); failures++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_forward();
        test_x0();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
